// File: rtl/div_pkg.sv
// Shared execute-stage defines: divider state codes, handshake levels and
// the DIV/DIVU opcodes alongside the HI/LO double-register bus type.
package div_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  typedef logic [63:0] DoubleRegBus;

endpackage

// File: rtl/div.sv
// Multi-cycle restoring divider for DIV/DIVU. Magnitudes are divided
// unsigned, one quotient bit per cycle, then sign-corrected on the way out.
module div
  import div_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  div_state_e state_q, state_d;

  logic [5:0]        cnt_q;
  logic [DATA_W-1:0] rem_q, quo_q, dvs_q;
  logic              sgn_q, s1_q, s2_q;

  logic              accept, iter_done, borrow;
  logic [DATA_W:0]   partial, diff;
  logic [DATA_W-1:0] q_fix, r_fix, dvd_abs, dvs_abs;
  logic              ready_d;
  logic [2*DATA_W-1:0] result_d;

  assign accept    = (start_i == DivStart) && !annul_i;
  assign iter_done = (cnt_q == 6'(DATA_W));

  assign dvd_abs = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign dvs_abs = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

  // quo_q doubles as the dividend shifter: its MSB feeds the partial remainder
  assign partial = {rem_q, quo_q[DATA_W-1]};
  assign diff    = partial - {1'b0, dvs_q};
  assign borrow  = diff[DATA_W];

  assign q_fix = (sgn_q && (s1_q ^ s2_q)) ? -quo_q : quo_q;
  assign r_fix = (sgn_q && s1_q) ? -rem_q : rem_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= DivFree;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DivFree:   if (accept) state_d = (opdata2_i == '0) ? DivByZero : DivOn;
      DivByZero: state_d = annul_i ? DivFree : DivEnd;
      DivOn: begin
        if (annul_i)        state_d = DivFree;
        else if (iter_done) state_d = DivEnd;
      end
      DivEnd:    if (annul_i || start_i == DivStop) state_d = DivFree;
      default:   state_d = DivFree;
    endcase
  end

  always_comb begin
    ready_d  = ready_o;
    result_d = result_o;
    case (state_q)
      DivByZero: if (!annul_i) begin
        ready_d  = DivResultReady;
        result_d = '0;
      end
      DivOn: if (!annul_i && iter_done) begin
        ready_d  = DivResultReady;
        result_d = {r_fix, q_fix};
      end
      DivEnd: if (annul_i || start_i == DivStop) begin
        ready_d  = DivResultNotReady;
        result_d = '0;
      end
      default: begin
        ready_d  = DivResultNotReady;
        result_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_o  <= DivResultNotReady;
      result_o <= '0;
    end else begin
      ready_o  <= ready_d;
      result_o <= result_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      sgn_q <= 1'b0;
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
    end else if (state_q == DivFree && accept) begin
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= dvd_abs;
      dvs_q <= dvs_abs;
      sgn_q <= signed_div_i;
      s1_q  <= opdata1_i[DATA_W-1];
      s2_q  <= opdata2_i[DATA_W-1];
    end else if (state_q == DivOn && !iter_done) begin
      cnt_q <= cnt_q + 6'd1;
      rem_q <= borrow ? partial[DATA_W-1:0] : diff[DATA_W-1:0];
      quo_q <= {quo_q[DATA_W-2:0], ~borrow};
    end
  end

endmodule

// File: tb/tb_div.sv
// Randomized and directed checks of the divider against a longint
// arithmetic reference, including latency, annul and async reset cases.
module tb_div;

  logic        clk, rst, signed_div_i, start_i, annul_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic [63:0] result_o;
  logic        ready_o;

  int total = 0;
  int bad   = 0;

  div #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint la, lb, q, r;
    if (b == 32'd0) return 64'd0;
    la = sgn ? longint'($signed(a)) : longint'(a);
    lb = sgn ? longint'($signed(b)) : longint'(b);
    q  = la / lb;
    r  = la % lb;
    return {r[31:0], q[31:0]};
  endfunction

  // Accept on the next edge (E0), scramble operands, count edges until ready.
  task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        output int n);
    signed_div_i = sgn; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
    @(posedge clk); #1;
    opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = 1'($urandom);
    n = 0;
    while (!ready_o && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    int n;
    launch(sgn, a, b, n);
    chk({tag, "_lat"}, 65'(n), (b == 32'd0) ? 65'd1 : 65'd33);
    chk({tag, "_res"}, 65'(result_o), 65'(model(sgn, a, b)));
    start_i = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_clr"}, {ready_o, result_o}, 65'd0);
    @(posedge clk); #1;
  endtask

  task automatic watch_idle(input string tag, input int cycles);
    int hi = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (ready_o) hi++;
    end
    chk(tag, 65'(hi), 65'd0);
  endtask

  // Assert annul so that edge Ee samples it; no result may ever appear.
  task automatic annul_at(input int e, input string tag);
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    @(posedge clk); #1;
    repeat (e - 1) begin @(posedge clk); #1; end
    annul_i = 1'b1;
    @(posedge clk); #1;
    annul_i = 1'b0; start_i = 1'b0;
    watch_idle(tag, 40);
  endtask

  initial begin
    int n;
    logic sgn;
    logic [31:0] a, b;
    rst = 1'b0; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset", {ready_o, result_o}, 65'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    do_div(1'b0, 32'd100, 32'd7, "divu_100_7");
    chk("divu_100_7_val", 65'(model(1'b0, 32'd100, 32'd7)), {1'b0, 32'd2, 32'd14});
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    do_div(1'b1, 32'd7, 32'hFFFF_FFFE, "div_7_m2");
    do_div(1'b1, 32'd5, 32'd0, "div_by0");
    do_div(1'b0, 32'hDEAD_BEEF, 32'd0, "divu_by0");
    do_div(1'b0, 32'hFFFF_FFFF, 32'd1, "divu_max_1");
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");

    // Result held while start stays high
    launch(1'b1, 32'hFFFF_FF9C, 32'd7, n);
    repeat (3) begin @(posedge clk); #1; end
    chk("hold", {ready_o, result_o}, {1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFF2});
    start_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Annul and start together in FREE: annul wins, accept one edge later
    signed_div_i = 1'b0; opdata1_i = 32'd9; opdata2_i = 32'd3;
    start_i = 1'b1; annul_i = 1'b1;
    @(posedge clk); #1;
    annul_i = 1'b0;
    n = 0;
    while (!ready_o && n < 60) begin @(posedge clk); #1; n++; end
    chk("annul_start_lat", 65'(n), 65'd34);
    chk("annul_start_res", 65'(result_o), {33'd0, 32'd3});
    start_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    annul_at(10, "annul_e10");
    do_div(1'b0, 32'd9, 32'd3, "restart_9_3");
    annul_at(33, "annul_e33");
    annul_at(32, "annul_e32");

    // Async reset mid-division
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    @(posedge clk); #1;
    repeat (19) begin @(posedge clk); #1; end
    #2; rst = 1'b0; start_i = 1'b0;
    #1;
    chk("rst_mid", {ready_o, result_o}, 65'd0);
    @(posedge clk); #3; rst = 1'b1;
    watch_idle("rst_mid_idle", 40);
    do_div(1'b0, 32'd50, 32'd5, "divu_50_5");

    // Async reset while a result is being presented
    launch(1'b0, 32'd100, 32'd7, n);
    #2; rst = 1'b0; start_i = 1'b0;
    #1;
    chk("rst_end", {ready_o, result_o}, 65'd0);
    @(posedge clk); #3; rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 40; i++) begin
      sgn = 1'($urandom);
      a   = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'd1;
        2:       b = 32'hFFFF_FFFF;
        3:       b = $urandom_range(1, 255);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      do_div(sgn, a, b, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div.md
# div

Multi-cycle 32-bit integer divider with its own sequencing state machine, serving the DIV/DIVU instructions of the execute stage. Execute raises `start_i` with latched operands and holds its pipeline stall request high until `ready_o`. It then writes HI = remainder and LO = quotient through its normal HI/LO write path. One division is in flight at a time; `annul_i` lets a flush cancel it.

## Interface
- `DATA_W`, default 32: operand width. Only 32 is used and verified.

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset, asynchronous, active-low
- `signed_div_i`  in  1  1 = DIV (signed), 0 = DIVU
- `opdata1_i`  in  32  dividend
- `opdata2_i`  in  32  divisor
- `start_i`  in  1  request; held high by execute until `ready_o`, then dropped
- `annul_i`  in  1  cancel current/pending division (pipeline flush)
- `result_o`  out  64  {remainder[63:32], quotient[31:0]}
- `ready_o`  out  1  result valid

## Operation
States: FREE, BYZERO, ON, END (encodings in shared defines).

FREE:
- `start_i`=1, `annul_i`=0, divisor==0 → BYZERO.
- `start_i`=1, `annul_i`=0, divisor≠0 → ON.
  - Latch |dividend| and |divisor|; magnitude is taken only when `signed_div_i`=1 and the operand is negative.
  - Latch both operand sign bits and `signed_div_i`.
  - Clear iteration counter `cnt` (6 bits).
- Otherwise stay in FREE.

BYZERO → END with result 0 (defined value; no trap).

ON, restoring division, one quotient bit per cycle:
- Trial-subtract the 33-bit partial remainder minus {0, divisor}.
- Borrow → shift in 0, keep remainder. No borrow → shift in 1, replace remainder. `cnt++`.
- After `cnt` reaches 32, the next edge applies sign correction, registers `result_o`, and enters END.
- Quotient is negated iff signed and dividend sign ≠ divisor sign.
- Remainder is negated iff signed and dividend negative (remainder takes the dividend's sign).
- 0x80000000 / 0xFFFFFFFF signed → quotient 0x80000000, remainder 0 (wraps, no flag).

END:
- `ready_o`=1 and `result_o` held stable.
- `start_i`=0 or `annul_i`=1 → FREE, which clears `ready_o` and `result_o`.

`annul_i`=1 in BYZERO or ON → FREE on the next edge; no result is produced.

Operand inputs are sampled only at the FREE-state accept edge. Changes afterwards are ignored.

## Timing
- All outputs are registered. Reset values: `ready_o`=0, `result_o`=0, state=FREE, `cnt`=0.
- `rst` low at any time, including mid-division, forces reset values asynchronously. Operation resumes on the first edge after `rst` deasserts.
- E0 is the edge that samples `start_i` in FREE:
  - Nonzero divisor: iterations occur on E1..E32; END is entered at E33. `ready_o`=1 in the cycle after E33, i.e. 33 cycles of stall.
  - Divisor zero: END is entered at E1, so `ready_o`=1 in the cycle after E1.
- `ready_o` stays high until the edge that samples `start_i`=0 (or `annul_i`=1). It is low in the following cycle.
- A new `start_i` cannot be accepted on the same edge that leaves END. Minimum one FREE cycle between divisions.
- `annul_i` and `start_i` both high in FREE: annul wins, stay FREE.
- `annul_i` on the iteration edge E32/E33: annul wins, result discarded.
- Zero combinational paths from inputs to outputs.

## Structure
- Shared defines file gains:
  - state codes `DivFree`, `DivByZero`, `DivOn`, `DivEnd` (2 bits);
  - `DivResultReady`/`DivResultNotReady`;
  - `DivStart`/`DivStop`;
  - `EXE_DIV_OP`, `EXE_DIVU_OP`, alongside the existing `EXE_*` opcodes and `DoubleRegBus`.
- No sub-module. The trial subtractor, abs/negate logic and FSM are a single module. Execute instantiates it and owns the stall request and HI/LO write-back.

## Test plan
- DIVU 100 / 7 → `ready_o` in the cycle after E33; `result_o` = {0x00000002, 0x0000000E}; `ready_o` clears the cycle after `start_i` drops.
- DIV −7 (0xFFFFFFF9) / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. DIV 7 / −2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- DIV/DIVU with divisor 0 → `ready_o` in the cycle after E1, `result_o` = 0. DIVU 0xFFFFFFFF / 1 → {0, 0xFFFFFFFF}.
- DIV 0x80000000 / 0xFFFFFFFF → {0x00000000, 0x80000000}.
- Start 100 / 7, assert `annul_i` at E10 → FREE at E11; `ready_o` never rises. Restart 9 / 3 → {0, 3} after 33 cycles.
- `rst` low mid-division at E20 → outputs 0 immediately. After release, a fresh DIVU 50 / 5 → {0, 10}.
